// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: all four CPOL/CPHA modes, MSB- or LSB-first, driven by SCLK edge strobes.
// Optional `SPI_SHIFT_LOOPBACK_EN adds a loopback input that samples the internal mosi instead of miso.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  ss,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic                  sclk_rise,
    input  logic                  sclk_fall,
    input  logic                  tx_load,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    input  logic                  miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0]  rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
    logic                   mosi_q, mosi_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   load, lead, trail, sample_e, shift_e, din;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign load  = tx_load && (state_q == IDLE) && !ss;
    assign lead  = cpol_q ? sclk_fall : sclk_rise;
    assign trail = cpol_q ? sclk_rise : sclk_fall;
    // Both strobes together is illegal; the sample edge wins and the shift is suppressed.
    assign sample_e = cpha_q ? trail : lead;
    assign shift_e  = (cpha_q ? lead : trail) && !(sclk_rise && sclk_fall);

`ifdef SPI_SHIFT_LOOPBACK_EN
    assign din = loopback ? mosi_q : miso;
`else
    assign din = miso;
`endif

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsbfe_d    = lsbfe_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    lsbfe_d   = lsbfe;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = XFER;
                    if (cpha) begin
                        tx_sr_d = tx_data;
                    end else begin
                        // CPHA=0 presents the first bit before the first leading edge.
                        mosi_d  = first_bit(tx_data, lsbfe);
                        tx_sr_d = shift_tx(tx_data, lsbfe);
                    end
                end
            end
            XFER: begin
                if (ss) begin
                    state_d = IDLE;
                    mosi_d  = 1'b0;
                end else begin
                    if (shift_e) begin
                        mosi_d  = first_bit(tx_sr_q, lsbfe_q);
                        tx_sr_d = shift_tx(tx_sr_q, lsbfe_q);
                    end
                    if (sample_e) begin
                        rx_sr_d   = lsbfe_q ? {din, rx_sr_q[DATA_WIDTH-1:1]}
                                            : {rx_sr_q[DATA_WIDTH-2:0], din};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1))
                            state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (ss) begin
                    mosi_d = 1'b0;
                end else begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbfe_q    <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsbfe_q    <= lsbfe_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign tx_ready = !busy;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: 8-bit and 16-bit instances share the clock, reset and SPI stimulus.
module tb_spi_shift_engine;

    logic        pclk = 1'b0, preset = 1'b1, ss = 1'b1;
    logic        cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
    logic        sclk_rise = 1'b0, sclk_fall = 1'b0, miso = 1'b0;
    logic        tx_load8 = 1'b0, tx_load16 = 1'b0;
    logic [31:0] tx_word = '0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    logic        tx_ready8, mosi8, rx_valid8, busy8;
    logic [7:0]  rx_data8;
    logic        tx_ready16, mosi16, rx_valid16, busy16;
    logic [15:0] rx_data16;

    bit          use16 = 1'b0;
    logic        mosi_s, busy_s, rx_valid_s, tx_ready_s;
    logic [31:0] rx_data_s;
    logic [31:0] q8[$];
    logic [31:0] q16[$];
    logic [31:0] last_rx8 = '0;
    int          tests = 0, errors = 0;

    always #5 pclk = ~pclk;

    spi_shift_engine #(.DATA_WIDTH(8)) u8 (
        .pclk(pclk), .preset(preset), .ss(ss), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .tx_load(tx_load8), .tx_data(tx_word[7:0]),
        .tx_ready(tx_ready8), .miso(miso),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .loopback(loopback),
`endif
        .mosi(mosi8), .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8)
    );

    spi_shift_engine #(.DATA_WIDTH(16)) u16 (
        .pclk(pclk), .preset(preset), .ss(ss), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .tx_load(tx_load16), .tx_data(tx_word[15:0]),
        .tx_ready(tx_ready16), .miso(miso),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .mosi(mosi16), .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16)
    );

    assign mosi_s     = use16 ? mosi16 : mosi8;
    assign busy_s     = use16 ? busy16 : busy8;
    assign rx_valid_s = use16 ? rx_valid16 : rx_valid8;
    assign tx_ready_s = use16 ? tx_ready16 : tx_ready8;
    assign rx_data_s  = use16 ? {16'h0, rx_data16} : {24'h0, rx_data8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One-cycle SCLK strobe; lead selects the leading edge for the current cpol.
    task automatic pulse(input bit lead);
        logic is_rise;
        is_rise   = lead ^ cpol;
        sclk_rise = is_rise;
        sclk_fall = !is_rise;
        tick();
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
    endtask

    function automatic logic bit_of(input logic [31:0] w, input int n, input int idx, input logic lsb);
        return lsb ? w[idx] : w[n-1-idx];
    endfunction

    task automatic xfer(input bit w16, input logic p, input logic h, input logic l,
                        input logic [31:0] tx, input logic [31:0] mw, input logic [31:0] exp,
                        input bit drop);
        int n;
        n     = w16 ? 16 : 8;
        use16 = w16;
        cpol  = p; cpha = h; lsbfe = l; tx_word = tx;
        if (w16) q16.push_back(exp); else q8.push_back(exp);
        if (w16) tx_load16 = 1'b1; else tx_load8 = 1'b1;
        tick();
        tx_load16 = 1'b0; tx_load8 = 1'b0;
        chk1("busy_after_load", busy_s, 1'b1);
        if (!h) chk1("mosi_first_bit", mosi_s, bit_of(tx, n, 0, l));
        for (int i = 0; i < n; i++) begin
            if (drop && i == 2) begin
                chk1("tx_ready_while_busy", tx_ready_s, 1'b0);
                tx_word = ~tx;
                if (w16) tx_load16 = 1'b1; else tx_load8 = 1'b1;
                tick();
                tx_load16 = 1'b0; tx_load8 = 1'b0;
                tx_word = tx;
            end
            miso = bit_of(mw, n, i, l);
            if (!h) begin
                pulse(1'b1);
                chk1("mosi_hold_on_lead", mosi_s, bit_of(tx, n, i, l));
                if (i < n - 1) begin
                    pulse(1'b0);
                    chk1("mosi_shift_on_trail", mosi_s, bit_of(tx, n, i + 1, l));
                end
            end else begin
                pulse(1'b1);
                chk1("mosi_shift_on_lead", mosi_s, bit_of(tx, n, i, l));
                pulse(1'b0);
                chk1("mosi_hold_on_trail", mosi_s, bit_of(tx, n, i, l));
            end
        end
        chk1("done_busy", busy_s, 1'b1);
        chk1("done_no_valid_yet", rx_valid_s, 1'b0);
        tick();
        chk1("rx_valid_2_cycles", rx_valid_s, 1'b1);
        chk1("busy_dropped", busy_s, 1'b0);
        chk("rx_data", rx_data_s, exp);
        chk1("mosi_holds_last", mosi_s, bit_of(tx, n, n - 1, l));
        tick();
        chk1("rx_valid_one_cycle", rx_valid_s, 1'b0);
        if (!w16) last_rx8 = exp;
    endtask

    always @(negedge pclk) begin
        if (rx_valid8) begin
            if (q8.size() == 0) begin
                tests++; errors++;
                $display("FAIL sb8_unexpected_rx_valid: got rx_data 0x%0h, expected no pulse", rx_data8);
            end else begin
                chk("sb8_rx_data", {24'h0, rx_data8}, q8.pop_front());
            end
        end
        if (rx_valid16) begin
            if (q16.size() == 0) begin
                tests++; errors++;
                $display("FAIL sb16_unexpected_rx_valid: got rx_data 0x%0h, expected no pulse", rx_data16);
            end else begin
                chk("sb16_rx_data", {16'h0, rx_data16}, q16.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk1("reset_mosi", mosi8, 1'b0);
        chk("reset_rx_data", {24'h0, rx_data8}, 32'h0);
        chk1("reset_rx_valid", rx_valid8, 1'b0);
        chk1("reset_busy", busy8, 1'b0);
        chk1("reset_tx_ready", tx_ready8, 1'b1);
        @(negedge pclk);
        preset = 1'b0;
        ss     = 1'b0;
        tick();

        // mode 0 MSB-first, then modes 1/2/3 LSB-first (mode 3 with a dropped load mid-transfer)
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 32'hA5, 32'h3C, 32'h3C, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 1'b1, 32'h81, 32'h96, 32'h96, 1'b0);
        xfer(1'b0, 1'b1, 1'b0, 1'b1, 32'h81, 32'h4B, 32'h4B, 1'b0);
        xfer(1'b0, 1'b1, 1'b1, 1'b1, 32'h81, 32'hE1, 32'hE1, 1'b1);

        xfer(1'b1, 1'b0, 1'b0, 1'b0, 32'hBEEF, 32'h1234, 32'h1234, 1'b0);

        // abort after the third sample
        use16 = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; tx_word = 32'hA5;
        tx_load8 = 1'b1;
        tick();
        tx_load8 = 1'b0;
        pulse(1'b1); pulse(1'b0); pulse(1'b1); pulse(1'b0); pulse(1'b1);
        chk1("pre_abort_mosi", mosi8, 1'b1);
        ss = 1'b1;
        tick();
        chk1("abort_busy", busy8, 1'b0);
        chk1("abort_mosi", mosi8, 1'b0);
        chk1("abort_tx_ready", tx_ready8, 1'b1);
        repeat (3) tick();
        chk("abort_rx_hold", {24'h0, rx_data8}, last_rx8);
        ss = 1'b0;
        tick();
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 32'hA5, 32'h0F, 32'h0F, 1'b0);

        // async reset mid-transfer
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; tx_word = 32'h5A;
        tx_load8 = 1'b1;
        tick();
        tx_load8 = 1'b0;
        pulse(1'b1); pulse(1'b0); pulse(1'b1);
        chk1("pre_reset_mosi", mosi8, 1'b1);
        #2 preset = 1'b1;
        #1;
        chk1("midreset_mosi", mosi8, 1'b0);
        chk("midreset_rx_data", {24'h0, rx_data8}, 32'h0);
        chk1("midreset_rx_valid", rx_valid8, 1'b0);
        chk1("midreset_busy", busy8, 1'b0);
        chk1("midreset_tx_ready", tx_ready8, 1'b1);
        @(negedge pclk);
        preset   = 1'b0;
        last_rx8 = '0;
        tick();
        chk("post_reset_rx_data", {24'h0, rx_data8}, 32'h0);
        xfer(1'b0, 1'b1, 1'b1, 1'b0, 32'h3C, 32'hC6, 32'hC6, 1'b0);

`ifdef SPI_SHIFT_LOOPBACK_EN
        loopback = 1'b1;
        xfer(1'b0, 1'b1, 1'b1, 1'b0, 32'h5A, 32'h00, 32'h5A, 1'b0);
        xfer(1'b0, 1'b1, 1'b1, 1'b0, 32'h5A, 32'hFF, 32'h5A, 1'b0);
        loopback = 1'b0;
`endif

        repeat (4) tick();
        chk("sb8_queue_drained", 32'(q8.size()), 32'h0);
        chk("sb16_queue_drained", 32'(q16.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised full-duplex SPI shift engine. It serialises a DATA_WIDTH-bit transmit word onto mosi and deserialises miso into a receive word, in any of the four CPOL/CPHA modes and in either bit order. It sits between the SPI control/APB register block, which issues load requests and consumes received words, and the baud generator, which supplies single-cycle SCLK edge strobes.

## Interface
- DATA_WIDTH, 8: frame length in bits; legal range 2..32.
- CNT_W, $clog2(DATA_WIDTH+1): bit-counter width; derived, do not override.

- pclk  in  1  system clock; all logic on the rising edge.
- preset  in  1  asynchronous, active-high reset.
- ss  in  1  slave select, active low; high aborts any transfer.
- cpol, cpha, lsbfe  in  1 each  mode and bit order; captured on an accepted load.
- sclk_rise, sclk_fall  in  1 each  single-pclk strobes marking SCLK edges.
- tx_load  in  1  load request.
- tx_data  in  DATA_WIDTH  transmit word.
- tx_ready  out  1  engine idle; a load is accepted when tx_load && tx_ready && !ss.
- miso  in  1  serial input.
- mosi  out  1  serial output.
- rx_data  out  DATA_WIDTH  last completed receive word; held until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  transfer in progress.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - tx_ready=1.
  - On an accepted load:
    - latch tx_data into tx_sr;
    - capture cpol/cpha/lsbfe;
    - clear rx_sr and bit_cnt;
    - go to XFER.
- Leading edge = sclk_rise when cpol=0, sclk_fall when cpol=1. Trailing edge = the opposite strobe.
- CPHA=0:
  - mosi takes the first bit in the load cycle;
  - sample on leading edges;
  - shift out the next bit on each trailing edge, except after the final sample.
- CPHA=1:
  - mosi drives a bit on each leading edge, starting with the first bit;
  - sample on trailing edges.
- Bit order:
  - lsbfe=1: transmit bit 0 first; received bits fill bit 0 upward.
  - lsbfe=0: transmit MSB first; received bits fill the MSB downward.
- bit_cnt increments on each sample. When the DATA_WIDTH-th sample is taken, go to DONE.
- DONE (one cycle):
  - rx_data<=rx_sr;
  - rx_valid=1;
  - then IDLE.
  - mosi holds its last bit until the next load.
- ss high in XFER or DONE (abort):
  - next state IDLE;
  - rx_data unchanged;
  - no rx_valid pulse;
  - mosi<=0.
- sclk_rise and sclk_fall both high in one cycle is illegal; the engine acts on the sample edge only.
- Edge strobes and tx_load are ignored outside their applicable state. A tx_load while busy is dropped; the requester waits for tx_ready.
- Mode inputs changing mid-transfer have no effect.

## Timing
- Reset values: mosi=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1, state IDLE, counters 0. Reset mid-transfer returns to these immediately, with no rx_valid.
- busy=1 from the cycle after an accepted load through the DONE cycle. tx_ready=!busy.
- Edge strobe to mosi update: 1 pclk, registered.
- Final sample strobe to rx_valid: 2 pclk (the XFER→DONE register, then the DONE output).
- Back-to-back: a new load is accepted in the first IDLE cycle after DONE.

## Configuration
- SPI_SHIFT_LOOPBACK_EN defined:
  - adds input loopback (1 bit);
  - when loopback=1, the sampling path uses the internal mosi value instead of miso, so rx_data equals tx_data for every mode and order;
  - mosi still drives the pin.
- Not defined: the port is absent and sampling always uses miso.

## Test plan
- DATA_WIDTH=8, mode 0, lsbfe=0, tx_data=0xA5, miso driven with 0x3C MSB-first -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; busy drops after DONE.
- Modes 1/2/3 with lsbfe=1, tx_data=0x81 -> mosi bits are 1,0,0,0,0,0,0,1, each changing only on the correct shift edge (the leading edge for CPHA=1); rx_data matches the miso pattern in every mode.
- DATA_WIDTH=16, tx_data=0xBEEF, miso=0x1234 MSB-first -> rx_data=0x1234 after exactly 16 samples; rx_valid 2 cycles after the 16th sample strobe.
- ss raised after the 3rd sample -> IDLE next cycle; rx_valid never asserts; rx_data keeps its prior value; mosi=0; next load works normally.
- preset pulsed mid-transfer, and tx_load asserted while busy -> all outputs at reset values immediately after preset; the load while busy is ignored and tx_data is not relatched.
- With SPI_SHIFT_LOOPBACK_EN and loopback=1, mode 3, tx_data=0x5A -> rx_data=0x5A regardless of the miso level.
